dff_bank_arbiter: RTL

Round-robin arbiter and write sequencer for a shared register bank built from master-slave D flip-flops, which has one write port. Up to N_REQ requesters post a data word. The arbiter grants one requester at a time and drives a single-cycle write enable with the captured word. It then holds the bus for a settle window so the master/slave stages fully propagate, and returns a one-cycle acknowledge. It sits between requester logic and the bank's D/enable inputs.

---
 rtl/dff_bank_arbiter.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/dff_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dff_bank_arbiter
// Purpose  : Round-robin arbiter and write sequencer for a single-write-port
//            register bank built from master-slave D flip-flops. One requester
//            is granted at a time. The captured word is written with a
//            one-cycle WE pulse. WDATA/GNT are then held for a settle window
//            so both latch stages propagate, and the transaction closes with
//            a one-cycle ACK to the granted requester.
// Ports    : CLK   - clock, all state changes on the rising edge
//            RST   - synchronous active-high reset
//            REQ   - per-requester request level (bit i = requester i)
//            DIN   - packed requester data, slice i = DIN[i*WIDTH +: WIDTH]
//            GNT   - one-hot grant (registered)
//            WE    - bank write enable, single-cycle pulse (registered)
//            WDATA - word driven to the bank D inputs (registered)
//            ACK   - one-hot, single-cycle completion pulse (registered)
//            BUSY  - transaction in progress (registered)
// Revision : 1.0 - initial release
// ============================================================================
module dff_bank_arbiter #(
    parameter int N_REQ      = 4,
    parameter int WIDTH      = 8,
    parameter int SETTLE_CYC = 2
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [N_REQ-1:0]       REQ,
    input  logic [N_REQ*WIDTH-1:0] DIN,
    output logic [N_REQ-1:0]       GNT,
    output logic                   WE,
    output logic [WIDTH-1:0]       WDATA,
    output logic [N_REQ-1:0]       ACK,
    output logic                   BUSY
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_ptr_w = $clog2(N_REQ);
    // One extra bit so ptr + offset cannot overflow before the modulo fold.
    localparam int c_sum_w = c_ptr_w + 1;

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_write  = 2'd1;
    localparam logic [1:0] c_st_settle = 2'd2;
    localparam logic [1:0] c_st_done   = 2'd3;

    localparam logic [N_REQ-1:0]   c_one_hot0    = N_REQ'(1);
    localparam logic [3:0]         c_settle_init = 4'(SETTLE_CYC - 1);
    localparam logic [c_ptr_w-1:0] c_last_idx    = c_ptr_w'(N_REQ - 1);
    localparam logic [c_sum_w-1:0] c_n_req_sum   = c_sum_w'(N_REQ);

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [c_ptr_w-1:0] r_ptr;     // highest-priority requester
    logic [c_ptr_w-1:0] r_sel;     // index of the requester being served
    logic [3:0]         r_cnt;     // settle countdown
    logic [N_REQ-1:0]   r_gnt;
    logic               r_we;
    logic [WIDTH-1:0]   r_wdata;
    logic [N_REQ-1:0]   r_ack;
    logic               r_busy;

    // ------------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------------
    logic [1:0]         w_state_nxt;
    logic [c_ptr_w-1:0] w_ptr_nxt;
    logic [c_ptr_w-1:0] w_sel_nxt;
    logic [3:0]         w_cnt_nxt;
    logic [N_REQ-1:0]   w_gnt_nxt;
    logic               w_we_nxt;
    logic [WIDTH-1:0]   w_wdata_nxt;
    logic [N_REQ-1:0]   w_ack_nxt;
    logic               w_busy_nxt;

    // ------------------------------------------------------------------------
    // Round-robin pick
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0]   w_din [N_REQ];
    logic               w_found;
    logic [c_ptr_w-1:0] w_pick;
    logic [c_sum_w-1:0] w_sum;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_din_unpack
            assign w_din[gi] = DIN[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Scan ptr, ptr+1, ... wrapping modulo N_REQ; the first set request wins.
    // The fold is a single subtract because ptr + offset < 2*N_REQ.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_sum   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + c_sum_w'(k);
            if (w_sum >= c_n_req_sum) begin
                w_sum = w_sum - c_n_req_sum;
            end
            if (!w_found && REQ[w_sum[c_ptr_w-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_sum[c_ptr_w-1:0];
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state and next-output logic
    // ------------------------------------------------------------------------
    // WE and ACK default to 0, which makes them single-cycle pulses. WDATA
    // defaults to its held value so the bank D inputs stay stable between
    // transactions.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_sel_nxt   = r_sel;
        w_cnt_nxt   = r_cnt;
        w_gnt_nxt   = r_gnt;
        w_we_nxt    = 1'b0;
        w_wdata_nxt = r_wdata;
        w_ack_nxt   = '0;
        w_busy_nxt  = r_busy;

        case (r_state)
            c_st_idle: begin
                if (w_found) begin
                    // DIN is sampled only here; later changes cannot reach WDATA.
                    w_state_nxt = c_st_write;
                    w_sel_nxt   = w_pick;
                    w_gnt_nxt   = c_one_hot0 << w_pick;
                    w_we_nxt    = 1'b1;
                    w_wdata_nxt = w_din[w_pick];
                    w_busy_nxt  = 1'b1;
                end
            end

            c_st_write: begin
                w_state_nxt = c_st_settle;
                w_cnt_nxt   = c_settle_init;
            end

            c_st_settle: begin
                // The counter is loaded with SETTLE_CYC-1 and the exit happens
                // on zero, so this state lasts exactly SETTLE_CYC cycles.
                if (r_cnt == 4'd0) begin
                    w_state_nxt = c_st_done;
                    w_ack_nxt   = r_gnt;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end

            c_st_done: begin
                // A mandatory IDLE cycle follows, so a requester that keeps
                // REQ high competes again under the advanced pointer.
                w_state_nxt = c_st_idle;
                w_gnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
                w_ptr_nxt   = (r_sel == c_last_idx) ? '0 : r_sel + c_ptr_w'(1);
            end

            default: begin
                w_state_nxt = c_st_idle;
                w_gnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    // Reset clears everything, including an in-flight transaction. That
    // transaction is abandoned without an ACK.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_st_idle;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_ack   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_sel   <= w_sel_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gnt   <= w_gnt_nxt;
            r_we    <= w_we_nxt;
            r_wdata <= w_wdata_nxt;
            r_ack   <= w_ack_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign GNT   = r_gnt;
    assign WE    = r_we;
    assign WDATA = r_wdata;
    assign ACK   = r_ack;
    assign BUSY  = r_busy;

endmodule
`default_nettype wire
